// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer
//   Multi-cycle driver for the 8-bit Alu8bit. A W-bit command (W = 8*N_SLICES)
//   is issued to the ALU one byte slice at a time, least-significant first,
//   with each slice's carry-out chained into the next slice's carry-in. The
//   assembled result is returned on a valid/ready response port.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_a, cmd_b [W]        operands
//   cmd_cin                 carry into slice 0
//   cmd_sel [4]             ALU op select, applied to every slice
//   alu_a/alu_b/alu_cin/alu_sel   registered drive to Alu8bit
//   alu_s, alu_cout         Alu8bit outputs
//   rsp_valid/rsp_ready     response handshake (valid only in DONE)
//   rsp_s [W], rsp_cout     assembled result, carry out of last slice
//   rsp_zero                rsp_s == 0
module alu_slice_sequencer #(
  parameter int N_SLICES   = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [8*N_SLICES-1:0]   cmd_a,
  input  logic [8*N_SLICES-1:0]   cmd_b,
  input  logic                    cmd_cin,
  input  logic [3:0]              cmd_sel,
  output logic [7:0]              alu_a,
  output logic [7:0]              alu_b,
  output logic                    alu_cin,
  output logic [3:0]              alu_sel,
  input  logic [7:0]              alu_s,
  input  logic                    alu_cout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*N_SLICES-1:0]   rsp_s,
  output logic                    rsp_cout,
  output logic                    rsp_zero
);

  localparam int W  = 8 * N_SLICES;
  localparam int IW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX    = IW'(N_SLICES - 1);
  localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  logic [1:0]    state_q,    state_d;
  logic [W-1:0]  a_q,        a_d;
  logic [W-1:0]  b_q,        b_d;
  logic [IW-1:0] idx_q,      idx_d;
  logic [3:0]    cnt_q,      cnt_d;
  logic [W-1:0]  res_q,      res_d;
  logic [7:0]    alu_a_q,    alu_a_d;
  logic [7:0]    alu_b_q,    alu_b_d;
  logic          alu_cin_q,  alu_cin_d;   // doubles as the inter-slice carry register
  logic [3:0]    alu_sel_q,  alu_sel_d;
  logic [W-1:0]  rsp_s_q,    rsp_s_d;
  logic          rsp_cout_q, rsp_cout_d;
  logic          rsp_zero_q, rsp_zero_d;

  logic [W-1:0]  slice_res;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_cin_d  = alu_cin_q;
    alu_sel_d  = alu_sel_q;
    rsp_s_d    = rsp_s_q;
    rsp_cout_d = rsp_cout_q;
    rsp_zero_d = rsp_zero_q;

    // Partial result with the current slice merged in.
    slice_res = res_q;
    slice_res[8*idx_q +: 8] = alu_s;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          a_d       = cmd_a;
          b_d       = cmd_b;
          alu_a_d   = cmd_a[7:0];
          alu_b_d   = cmd_b[7:0];
          alu_cin_d = cmd_cin;
          alu_sel_d = cmd_sel;
          idx_d     = '0;
          cnt_d     = SETTLE_LOAD;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == 4'd0) begin
          res_d = slice_res;
          if (idx_q != LAST_IDX) begin
            idx_d     = idx_q + 1'b1;
            cnt_d     = SETTLE_LOAD;
            alu_a_d   = a_q[8*idx_d +: 8];
            alu_b_d   = b_q[8*idx_d +: 8];
            alu_cin_d = alu_cout;
          end else begin
            // Response registers are only written here, so they stay put
            // through DONE and after the handshake.
            rsp_s_d    = slice_res;
            rsp_cout_d = alu_cout;
            rsp_zero_d = (slice_res == '0);
            alu_a_d    = '0;
            alu_b_d    = '0;
            alu_cin_d  = 1'b0;
            alu_sel_d  = '0;
            state_d    = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_cin_q  <= 1'b0;
      alu_sel_q  <= '0;
      rsp_s_q    <= '0;
      rsp_cout_q <= 1'b0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_cin_q  <= alu_cin_d;
      alu_sel_q  <= alu_sel_d;
      rsp_s_q    <= rsp_s_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cin   = alu_cin_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
module tb_alu_slice_sequencer;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // DUT with SETTLE_CYC=1
  logic         cmd_valid, cmd_ready, cmd_cin, rsp_valid, rsp_ready, rsp_cout, rsp_zero;
  logic [W-1:0] cmd_a, cmd_b, rsp_s;
  logic [3:0]   cmd_sel, alu_sel;
  logic [7:0]   alu_a, alu_b, alu_s;
  logic         alu_cin, alu_cout;

  // DUT with SETTLE_CYC=3
  logic         cmd_valid3, cmd_ready3, cmd_cin3, rsp_valid3, rsp_ready3, rsp_cout3, rsp_zero3;
  logic [W-1:0] cmd_a3, cmd_b3, rsp_s3;
  logic [3:0]   cmd_sel3, alu_sel3;
  logic [7:0]   alu_a3, alu_b3, alu_s3;
  logic         alu_cin3, alu_cout3;

  // ALU stubs: plain add for any sel
  assign {alu_cout, alu_s}   = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
  assign {alu_cout3, alu_s3} = {1'b0, alu_a3} + {1'b0, alu_b3} + {8'd0, alu_cin3};

  alu_slice_sequencer #(.N_SLICES(2), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_cin(cmd_cin), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sel(alu_sel),
    .alu_s(alu_s), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_s(rsp_s),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero)
  );

  alu_slice_sequencer #(.N_SLICES(2), .SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_a(cmd_a3), .cmd_b(cmd_b3),
    .cmd_cin(cmd_cin3), .cmd_sel(cmd_sel3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_cin(alu_cin3), .alu_sel(alu_sel3),
    .alu_s(alu_s3), .alu_cout(alu_cout3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_s(rsp_s3),
    .rsp_cout(rsp_cout3), .rsp_zero(rsp_zero3)
  );

  // Scoreboards: {cout, s}
  logic [W:0] sb_q[$];
  logic [W:0] sb3_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // Drive a command and step through the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic [3:0] sel);
    int unsigned n;
    cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_sel = sel; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 40) begin step(); n++; end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
    end
    step();
    sb_q.push_back(model(a, b, cin));
    cmd_valid = 1'b0;
  endtask

  // Wait for rsp_valid, compare against scoreboard head, then handshake.
  task automatic collect(input string name);
    int unsigned n;
    logic [W:0] exp;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin step(); n++; end
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout: rsp_valid=%b required 1", name, rsp_valid);
      return;
    end
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s_unexpected: response with empty scoreboard, rsp_s=%h", name, rsp_s);
      return;
    end
    exp = sb_q.pop_front();
    if ({rsp_cout, rsp_s} !== exp || rsp_zero !== (exp[W-1:0] == '0)) begin
      miscompares++;
      $display("FAIL %s_rsp: got s=%h cout=%b zero=%b required s=%h cout=%b zero=%b",
               name, rsp_s, rsp_cout, rsp_zero, exp[W-1:0], exp[W], (exp[W-1:0] == '0));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || {rsp_cout, rsp_s} !== exp) begin
      miscompares++;
      $display("FAIL %s_post_hs: rsp_valid=%b cmd_ready=%b s=%h required 0 1 %h",
               name, rsp_valid, cmd_ready, rsp_s, exp[W-1:0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 0; cmd_a = '0; cmd_b = '0; cmd_cin = 0; cmd_sel = '0; rsp_ready = 0;
    cmd_valid3 = 0; cmd_a3 = '0; cmd_b3 = '0; cmd_cin3 = 0; cmd_sel3 = '0; rsp_ready3 = 0;
    repeat (3) step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({alu_a, alu_b, alu_cin, alu_sel, rsp_valid, rsp_s, rsp_cout, rsp_zero} !== '0 ||
          cmd_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_state[%0d]: alu=%h/%h/%b/%h rsp=%b/%h/%b/%b cmd_ready=%b required zeros, cmd_ready=1",
                 k, alu_a, alu_b, alu_cin, alu_sel, rsp_valid, rsp_s, rsp_cout, rsp_zero, cmd_ready);
      end
      vectors++;
      if ({alu_a3, alu_b3, alu_cin3, alu_sel3, rsp_valid3, rsp_s3, rsp_cout3, rsp_zero3} !== '0 ||
          cmd_ready3 !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_state3[%0d]: rsp_valid=%b cmd_ready=%b required 0 1", k, rsp_valid3, cmd_ready3);
      end
      step();
    end
  endtask

  task automatic test_add_carry();
    issue(16'h00FF, 16'h0001, 1'b0, 4'b0100);
    vectors++;
    if (alu_a !== 8'hFF || alu_b !== 8'h01 || alu_cin !== 1'b0 || alu_sel !== 4'b0100 ||
        cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL add_slice0: a=%h b=%h cin=%b sel=%b rdy=%b vld=%b required ff 01 0 0100 0 0",
               alu_a, alu_b, alu_cin, alu_sel, cmd_ready, rsp_valid);
    end
    step();
    vectors++;
    if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_cin !== 1'b1 || alu_sel !== 4'b0100 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL add_slice1: a=%h b=%h cin=%b sel=%b vld=%b required 00 00 1 0100 0",
               alu_a, alu_b, alu_cin, alu_sel, rsp_valid);
    end
    step();
    vectors++;
    if (rsp_valid !== 1'b1 || {alu_a, alu_b, alu_cin, alu_sel} !== '0) begin
      miscompares++;
      $display("FAIL add_latency: rsp_valid=%b alu=%h/%h/%b/%h required 1 and zeros",
               rsp_valid, alu_a, alu_b, alu_cin, alu_sel);
    end
    collect("add_carry");
  endtask

  task automatic test_wrap();
    issue(16'hFFFF, 16'h0001, 1'b0, 4'b0100);
    collect("wrap");
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp;
    issue(16'h1111, 16'h2222, 1'b0, 4'b0100);
    exp = model(16'h1111, 16'h2222, 1'b0);
    repeat (2) step();
    cmd_a = 16'h0F0F; cmd_b = 16'h00F1; cmd_cin = 1'b1; cmd_sel = 4'b0100; cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || {rsp_cout, rsp_s} !== exp) begin
        miscompares++;
        $display("FAIL backpressure[%0d]: vld=%b rdy=%b s=%h required 1 0 %h",
                 k, rsp_valid, cmd_ready, rsp_s, exp[W-1:0]);
      end
      step();
    end
    collect("bp_first");
    // Pending command is accepted on the edge after the handshake.
    sb_q.push_back(model(16'h0F0F, 16'h00F1, 1'b1));
    step();
    cmd_valid = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b0 || alu_a !== 8'h0F || alu_b !== 8'hF1 || alu_cin !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_accept: rdy=%b a=%h b=%h cin=%b required 0 0f f1 1", cmd_ready, alu_a, alu_b, alu_cin);
    end
    collect("bp_second");
  endtask

  task automatic test_reset_mid();
    issue(16'hAAAA, 16'h5555, 1'b1, 4'b0100);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sb_q.delete();
    vectors++;
    if ({alu_a, alu_b, alu_cin, alu_sel} !== '0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        rsp_s !== '0 || rsp_cout !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state: alu=%h/%h/%b/%h rdy=%b vld=%b s=%h required zeros, rdy=1",
               alu_a, alu_b, alu_cin, alu_sel, cmd_ready, rsp_valid, rsp_s);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL midreset_quiet[%0d]: vld=%b rdy=%b required 0 1", k, rsp_valid, cmd_ready);
      end
    end
    issue(16'h1234, 16'h0001, 1'b0, 4'b0100);
    collect("after_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic cin;
    for (int k = 0; k < 6; k++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
      issue(a, b, cin, 4'($urandom));
      repeat ($urandom_range(0, 3)) step();
      collect("random");
    end
  endtask

  task automatic test_settle();
    logic [W:0] exp;
    logic [7:0] ea, eb;
    logic ec;
    int unsigned n;
    cmd_a3 = 16'h80FF; cmd_b3 = 16'h7F01; cmd_cin3 = 1'b0; cmd_sel3 = 4'b1010; cmd_valid3 = 1'b1;
    n = 0;
    while (!cmd_ready3 && n < 40) begin step(); n++; end
    step();
    cmd_valid3 = 1'b0;
    sb3_q.push_back(model(16'h80FF, 16'h7F01, 1'b0));
    for (int k = 0; k < 6; k++) begin
      ea = (k < 3) ? 8'hFF : 8'h80;
      eb = (k < 3) ? 8'h01 : 8'h7F;
      ec = (k < 3) ? 1'b0 : 1'b1;
      vectors++;
      if (alu_a3 !== ea || alu_b3 !== eb || alu_cin3 !== ec || alu_sel3 !== 4'b1010 || rsp_valid3 !== 1'b0) begin
        miscompares++;
        $display("FAIL settle[%0d]: a=%h b=%h cin=%b sel=%b vld=%b required %h %h %b 1010 0",
                 k, alu_a3, alu_b3, alu_cin3, alu_sel3, rsp_valid3, ea, eb, ec);
      end
      step();
    end
    exp = sb3_q.pop_front();
    vectors++;
    if (rsp_valid3 !== 1'b1 || {rsp_cout3, rsp_s3} !== exp || rsp_zero3 !== (exp[W-1:0] == '0)) begin
      miscompares++;
      $display("FAIL settle_rsp: vld=%b s=%h cout=%b zero=%b required 1 %h %b %b",
               rsp_valid3, rsp_s3, rsp_cout3, rsp_zero3, exp[W-1:0], exp[W], (exp[W-1:0] == '0));
    end
    rsp_ready3 = 1'b1;
    step();
    rsp_ready3 = 1'b0;
    vectors++;
    if (rsp_valid3 !== 1'b0 || cmd_ready3 !== 1'b1) begin
      miscompares++;
      $display("FAIL settle_hs: vld=%b rdy=%b required 0 1", rsp_valid3, cmd_ready3);
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_slice_sequencer.md
Name: alu_slice_sequencer

Overview:
- Multi-cycle driver for the 8-bit gate-level ALU (Alu8bit).
- Accepts a wide operation on a valid/ready command port and issues it to the ALU one 8-bit slice at a time, least-significant slice first.
- Chains each slice's carry-out into the next slice's carry-in and returns the assembled result on a valid/ready response port.
- Synthesizable replacement for hand-driven stimulus when Alu8bit is used inside larger datapaths.

Parameters:
- N_SLICES, 2, number of 8-bit slices; operand width W = 8*N_SLICES.
- SETTLE_CYC, 1, cycles each slice is held on the ALU inputs before capture (gate-delay margin); legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_a  in  W  operand A.
- cmd_b  in  W  operand B.
- cmd_cin  in  1  carry-in to slice 0.
- cmd_sel  in  4  ALU operation select; passed unchanged to every slice.
- alu_a  out  8  to Alu8bit a.
- alu_b  out  8  to Alu8bit b.
- alu_cin  out  1  to Alu8bit cin.
- alu_sel  out  4  to Alu8bit sel.
- alu_s  in  8  from Alu8bit s.
- alu_cout  in  1  from Alu8bit cout.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_s  out  W  assembled result.
- rsp_cout  out  1  carry-out of the last slice.
- rsp_zero  out  1  1 when rsp_s == 0.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - All outputs and internal registers go to 0, except cmd_ready, which is 1 in IDLE.
  - Reset mid-operation aborts the operation: no response, partial result discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1; alu_a/alu_b/alu_cin/alu_sel driven 0.
  - When cmd_valid=1 at an edge: latch cmd_a/cmd_b/cmd_sel, set carry register = cmd_cin, slice index i=0, settle counter=SETTLE_CYC-1; go to RUN.
- RUN:
  - cmd_ready=0.
  - alu_a = a[8i+7:8i], alu_b = b[8i+7:8i], alu_cin = carry register, alu_sel = latched sel; all registered and stable for exactly SETTLE_CYC cycles per slice.
  - On the edge where the settle counter is 0: write alu_s into result[8i+7:8i], carry register = alu_cout.
  - Then, if i < N_SLICES-1: i increments and the counter reloads.
  - Otherwise: rsp_cout = alu_cout and the state goes to DONE.
- DONE:
  - rsp_valid=1; rsp_s, rsp_cout and rsp_zero held stable until an edge with rsp_ready=1.
  - On that edge: rsp_valid goes to 0, state goes to IDLE.
  - cmd_ready=0 throughout DONE; a command presented during the handshake cycle is accepted on the following edge (no overlap).
- Latency: command accepted at edge E0 gives rsp_valid=1 after edge E0 + N_SLICES*SETTLE_CYC. Throughput is one command per N_SLICES*SETTLE_CYC + 2 cycles.
- rsp_zero is computed from the full W-bit result only; cout does not affect it.
- rsp_s and rsp_cout keep their last values after the handshake until the next result is written; rsp_valid alone qualifies them.
- Signals with no meaning in the current state (e.g. cmd_* outside IDLE, rsp_ready outside DONE) are ignored.

Test Plan:
Bench uses an ALU stub where {alu_cout, alu_s} = alu_a + alu_b + alu_cin, for any sel.
1. rst_n=0 for 3 cycles, then 1 → all outputs 0, cmd_ready=1; with cmd_valid=0, state stays IDLE.
2. Add with carry into slice 1 (N_SLICES=2, SETTLE_CYC=1): a=0x00FF, b=0x0001, cin=0, sel=4'b0100.
   - Slice 0 drives alu_a=0xFF, alu_b=0x01, alu_cin=0; slice 1 drives 0x00, 0x00, alu_cin=1; alu_sel=0100 throughout.
   - rsp_valid=1 two edges after accept, with rsp_s=0x0100, rsp_cout=0, rsp_zero=0.
3. Wrap-around: a=0xFFFF, b=0x0001, cin=0 → rsp_s=0x0000, rsp_cout=1, rsp_zero=1.
4. Back-pressure: rsp_ready=0 for 5 cycles with cmd_valid=1 held.
   - Response stays stable and cmd_ready=0 throughout.
   - Handshake completes on the first edge with rsp_ready=1; the pending command is accepted on the next edge.
5. Reset mid-operation: rst_n=0 one cycle after accept → rsp_valid never rises, alu_* return to 0, cmd_ready=1 after release; the next command a=0x1234, b=0x0001 gives rsp_s=0x1235.
6. Settle timing (SETTLE_CYC=3, N_SLICES=2): each alu_* slice value is held for exactly 3 cycles; rsp_valid rises 6 edges after accept.
